// File: rtl/rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_mux_arbiter (with helper mux2)
// Purpose  : Four-source round-robin arbiter with burst limit, steering a
//            4:1 mux2 tree onto a single ready/valid output channel.
// Revision : 1.0
// ============================================================================

module mux2 #(
  parameter int WIDTH = 8
) (
  input  logic             sel,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);
  assign out = sel ? in1 : in0;
endmodule

module rr_mux_arbiter #(
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic [WIDTH-1:0] c_in,
  input  logic [WIDTH-1:0] d_in,
  input  logic             ready_in,
  output logic [3:0]       gnt_out,
  output logic [1:0]       sel_out,
  output logic             valid_out,
  output logic [WIDTH-1:0] data_out,
  output logic             beat_out
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

  state_t     state_q, state_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] sel_q, sel_d;
  logic [3:0] gnt_q, gnt_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] pick;
  logic       found;
  logic [WIDTH-1:0] mux_lo, mux_hi;

  // Search starts one past the last-served index, wrapping back to it last.
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      if (!found && req_in[ptr_q + 2'(i)]) begin
        pick  = ptr_q + 2'(i);
        found = 1'b1;
      end
    end
  end

  assign valid_out = (state_q == GRANT) && req_in[sel_q];
  assign beat_out  = valid_out && ready_in;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    sel_d   = sel_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          sel_d   = pick;
          gnt_d   = 4'b0001 << pick;
          cnt_d   = 8'd0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // A dropped request also advances ptr, so the source forfeits its turn.
        if (!req_in[sel_q] || (beat_out && (cnt_q == LAST_BEAT))) begin
          ptr_d   = sel_q;
          gnt_d   = 4'b0000;
          cnt_d   = 8'd0;
          state_d = IDLE;
        end else if (beat_out) begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= 2'd3;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      sel_q   <= sel_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt_out = gnt_q;
  assign sel_out = sel_q;

  mux2 #(.WIDTH(WIDTH)) u_mux_lo (.sel(sel_q[0]), .in0(a_in),   .in1(b_in),   .out(mux_lo));
  mux2 #(.WIDTH(WIDTH)) u_mux_hi (.sel(sel_q[0]), .in0(c_in),   .in1(d_in),   .out(mux_hi));
  mux2 #(.WIDTH(WIDTH)) u_mux_top(.sel(sel_q[1]), .in0(mux_lo), .in1(mux_hi), .out(data_out));

endmodule

`default_nettype wire

// File: tb/tb_rr_mux_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_mux_arbiter
// Purpose  : Self-checking bench for rr_mux_arbiter (MAX_BURST 4 and 1 builds).
// Revision : 1.0
// ============================================================================
module tb_rr_mux_arbiter;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] req_in = 4'b0;
  logic ready_in = 1'b0;
  logic [WIDTH-1:0] a_in = '0, b_in = '0, c_in = '0, d_in = '0;

  logic [3:0] gnt0, gnt1;
  logic [1:0] sel0, sel1;
  logic valid0, valid1, beat0, beat1;
  logic [WIDTH-1:0] data0, data1;

  always #5 clk = ~clk;

  rr_mux_arbiter #(.WIDTH(WIDTH), .MAX_BURST(4)) dut4 (
    .clk(clk), .rst(rst), .req_in(req_in), .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .d_in(d_in), .ready_in(ready_in), .gnt_out(gnt0), .sel_out(sel0),
    .valid_out(valid0), .data_out(data0), .beat_out(beat0));

  rr_mux_arbiter #(.WIDTH(WIDTH), .MAX_BURST(1)) dut1 (
    .clk(clk), .rst(rst), .req_in(req_in), .a_in(a_in), .b_in(b_in), .c_in(c_in),
    .d_in(d_in), .ready_in(ready_in), .gnt_out(gnt1), .sel_out(sel1),
    .valid_out(valid1), .data_out(data1), .beat_out(beat1));

  int checks = 0;
  int passed = 0;

  // Reference model: granted index (-1 when idle), last-served index, beat count.
  int bursts [2] = '{4, 1};
  int m_gnt [2];
  int m_sel [2];
  int m_ptr [2];
  int m_cnt [2];

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      m_gnt[u] = -1;
      m_sel[u] = 0;
      m_ptr[u] = 3;
      m_cnt[u] = 0;
    end
  endtask

  task automatic model_step();
    bit v, b, hit;
    int idx;
    for (int u = 0; u < 2; u++) begin
      v = (m_gnt[u] >= 0) && req_in[m_sel[u]];
      b = v && ready_in;
      if (m_gnt[u] < 0) begin
        if (req_in != 4'b0) begin
          hit = 0;
          for (int k = 1; k <= 4; k++) begin
            idx = (m_ptr[u] + k) % 4;
            if (!hit && req_in[idx]) begin
              m_sel[u] = idx;
              hit = 1;
            end
          end
          m_gnt[u] = m_sel[u];
          m_cnt[u] = 0;
        end
      end else if (!req_in[m_sel[u]] || (b && (m_cnt[u] + 1 == bursts[u]))) begin
        m_ptr[u] = m_sel[u];
        m_gnt[u] = -1;
        m_cnt[u] = 0;
      end else if (b) begin
        m_cnt[u] = m_cnt[u] + 1;
      end
    end
  endtask

  function automatic logic [15:0] expv(int u);
    logic [WIDTH-1:0] src [4];
    logic v;
    logic [3:0] g;
    src = '{a_in, b_in, c_in, d_in};
    v = (m_gnt[u] >= 0) && req_in[m_sel[u]];
    g = (m_gnt[u] >= 0) ? 4'(1 << m_gnt[u]) : 4'b0;
    return {g, 2'(m_sel[u]), v, v & ready_in, src[m_sel[u]]};
  endfunction

  function automatic logic [15:0] obs(int u);
    if (u == 0) return {gnt0, sel0, valid0, beat0, data0};
    return {gnt1, sel1, valid1, beat1, data1};
  endfunction

  function automatic int oh2idx(logic [3:0] g);
    int r = -1;
    for (int i = 0; i < 4; i++) if (g[i]) r = i;
    return r;
  endfunction

  task automatic drive(input logic [3:0] r, input logic rdy);
    @(negedge clk);
    req_in   = r;
    ready_in = rdy;
    a_in = 8'($urandom);
    b_in = 8'($urandom);
    c_in = 8'($urandom);
    d_in = 8'($urandom);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_in = 4'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [15:0] got, want;
    @(negedge clk);
    rst = 1'b1;
    req_in = 4'b1111;
    ready_in = 1'b1;
    a_in = 8'h5a;
    model_reset();
    @(negedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      got = obs(u);
      want = expv(u);
      checks++;
      if (got !== want) $display("FAIL reset dut%0d: got %h, expected %h", u, got, want);
      else passed++;
    end
    req_in = 4'b0;
    rst = 1'b0;
  endtask

  task automatic test_reset_priority();
    logic [15:0] got, want;
    int order [$];
    int beats [$];
    int exp_order [5] = '{0, 1, 2, 3, 0};
    logic [3:0] prev = 4'b0;
    do_reset();
    for (int i = 0; i < 26; i++) begin
      drive(4'b1111, 1'b1);
      for (int u = 0; u < 2; u++) begin
        got = obs(u);
        want = expv(u);
        checks++;
        if (got !== want) $display("FAIL priority dut%0d cyc %0d: got %h, expected %h", u, i, got, want);
        else passed++;
      end
      if (gnt0 != 4'b0 && prev == 4'b0) begin
        order.push_back(oh2idx(gnt0));
        beats.push_back(0);
      end
      if (beat0 && beats.size() > 0) beats[beats.size()-1] = beats[beats.size()-1] + 1;
      prev = gnt0;
      model_step();
    end
    for (int j = 0; j < 5; j++) begin
      checks++;
      if (j >= order.size()) $display("FAIL priority_order grant %0d: got none, expected %0d", j, exp_order[j]);
      else if (order[j] != exp_order[j]) $display("FAIL priority_order grant %0d: got %0d, expected %0d", j, order[j], exp_order[j]);
      else passed++;
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (j >= beats.size()) $display("FAIL priority_beats grant %0d: got none, expected 4", j);
      else if (beats[j] != 4) $display("FAIL priority_beats grant %0d: got %0d, expected 4", j, beats[j]);
      else passed++;
    end
  endtask

  task automatic test_single();
    logic [15:0] got, want;
    for (int i = 0; i < 16; i++) begin
      drive(4'b0100, 1'b1);
      for (int u = 0; u < 2; u++) begin
        got = obs(u);
        want = expv(u);
        checks++;
        if (got !== want) $display("FAIL single dut%0d cyc %0d: got %h, expected %h", u, i, got, want);
        else passed++;
      end
      model_step();
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] got, want;
    do_reset();
    for (int i = 0; i < 14; i++) begin
      drive(4'b0010, !(i >= 3 && i < 8));
      for (int u = 0; u < 2; u++) begin
        got = obs(u);
        want = expv(u);
        checks++;
        if (got !== want) $display("FAIL backpressure dut%0d cyc %0d: got %h, expected %h", u, i, got, want);
        else passed++;
      end
      model_step();
    end
  endtask

  task automatic test_early_drop();
    logic [15:0] got, want;
    logic [3:0] r;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      r = (i < 2) ? 4'b1000 : 4'b1001;
      if (i == 2) r = 4'b0001;
      drive(r, 1'b1);
      for (int u = 0; u < 2; u++) begin
        got = obs(u);
        want = expv(u);
        checks++;
        if (got !== want) $display("FAIL early_drop dut%0d cyc %0d: got %h, expected %h", u, i, got, want);
        else passed++;
      end
      if (i == 4) begin
        checks++;
        if (gnt0 !== 4'b0001) $display("FAIL early_drop_next: got %b, expected 0001", gnt0);
        else passed++;
      end
      model_step();
    end
  endtask

  task automatic test_async_reset();
    logic [15:0] got, want;
    logic [5:0] q;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b1111, 1'b1);
      for (int u = 0; u < 2; u++) begin
        got = obs(u);
        want = expv(u);
        checks++;
        if (got !== want) $display("FAIL async_pre dut%0d cyc %0d: got %h, expected %h", u, i, got, want);
        else passed++;
      end
      if (i < 2) model_step();
    end
    // dut4 is mid beat 2 here; reset between edges.
    #1 rst = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      q = (u == 0) ? {gnt0, valid0, beat0} : {gnt1, valid1, beat1};
      checks++;
      if (q !== 6'b0) $display("FAIL async_reset dut%0d: got %b, expected 000000", u, q);
      else passed++;
    end
    model_reset();
    req_in = 4'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      drive(4'b1111, 1'b1);
      for (int u = 0; u < 2; u++) begin
        got = obs(u);
        want = expv(u);
        checks++;
        if (got !== want) $display("FAIL async_post dut%0d cyc %0d: got %h, expected %h", u, i, got, want);
        else passed++;
      end
      model_step();
    end
  endtask

  task automatic test_burst1();
    logic [15:0] got, want;
    int order [$];
    int exp_order [4] = '{1, 3, 1, 3};
    logic [3:0] prev = 4'b0;
    do_reset();
    for (int i = 0; i < 12; i++) begin
      drive(4'b1010, 1'b1);
      for (int u = 0; u < 2; u++) begin
        got = obs(u);
        want = expv(u);
        checks++;
        if (got !== want) $display("FAIL burst1 dut%0d cyc %0d: got %h, expected %h", u, i, got, want);
        else passed++;
      end
      if (gnt1 != 4'b0 && prev == 4'b0) order.push_back(oh2idx(gnt1));
      prev = gnt1;
      model_step();
    end
    for (int j = 0; j < 4; j++) begin
      checks++;
      if (j >= order.size()) $display("FAIL burst1_order grant %0d: got none, expected %0d", j, exp_order[j]);
      else if (order[j] != exp_order[j]) $display("FAIL burst1_order grant %0d: got %0d, expected %0d", j, order[j], exp_order[j]);
      else passed++;
    end
  endtask

  task automatic test_random();
    logic [15:0] got, want;
    logic [3:0] r = 4'b0;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      drive(r, $urandom_range(0, 3) != 0);
      for (int u = 0; u < 2; u++) begin
        got = obs(u);
        want = expv(u);
        checks++;
        if (got !== want) $display("FAIL random dut%0d cyc %0d: got %h, expected %h", u, i, got, want);
        else passed++;
      end
      model_step();
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_reset_priority();
    test_single();
    test_backpressure();
    test_early_drop();
    test_async_reset();
    test_burst1();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/rr_mux_arbiter.md
# rr_mux_arbiter

Four-requester round-robin arbiter that shares one WIDTH-bit output channel between four sources. It owns the 2-bit select of the team's 4:1 mux tree (Mux2) and sequences grants, burst limits and release. It sits between four producer blocks and a single downstream consumer that applies ready/valid backpressure.

## Interface
- WIDTH, 8, data width of each source and of the output channel
- MAX_BURST, 4, maximum accepted beats per grant; legal range 1..255
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req_in  input  4  request per source; a source holds it high while it has data
- a_in, b_in, c_in, d_in  input  WIDTH each  source 0..3 data
- ready_in  input  1  downstream accepts a beat this cycle
- gnt_out  output  4  one-hot grant, registered
- sel_out  output  2  registered mux select, equal to the granted index
- valid_out  output  1  combinational: state GRANT and req_in[sel_out]
- data_out  output  WIDTH  source selected by sel_out through a Mux2 instance
- beat_out  output  1  combinational: valid_out & ready_in, the transfer strobe

## Operation
- The block has two states, IDLE and GRANT.
- Internal registers:
  - ptr (2 bits): the last-served index.
  - cnt (8 bits): beats accepted in the current grant.
- IDLE:
  - If req_in != 0 at a clock edge, pick the first set bit searching ptr+1, ptr+2, ptr+3, ptr (mod 4).
  - Load sel_out with that index and gnt_out with its one-hot; clear cnt; go to GRANT.
  - If req_in == 0, stay in IDLE with gnt_out = 0.
- GRANT, one beat:
  - A beat is accepted at any edge with beat_out = 1; cnt increments.
- GRANT, release: go to IDLE at the edge where either condition holds.
  - (a) req_in[sel_out] = 0.
  - (b) beat_out = 1 and cnt = MAX_BURST-1.
  - On release: ptr <= sel_out, gnt_out <= 0, cnt <= 0. sel_out keeps its value.
- data_out is always the mux output for sel_out. It is meaningful only while valid_out = 1.
- Reset values:
  - state IDLE, gnt_out 0, sel_out 0, cnt 0.
  - ptr 3, so source 0 has first priority.
  - valid_out and beat_out evaluate to 0 in reset.
- Reset asserted mid-grant aborts the grant immediately. No further beat is signalled; the source must re-request.

## Timing
- Request to grant:
  - req_in sampled high at edge k in IDLE gives gnt_out and sel_out valid after edge k.
  - The first beat can be accepted at edge k+1.
- Release to next grant:
  - The release edge r returns to IDLE with gnt_out = 0 during cycle r..r+1.
  - The next grant appears after edge r+1.
  - Exactly one bubble cycle separates consecutive grants, including back-to-back grants to the same source.
- Full-rate burst: with ready_in held high, MAX_BURST beats are accepted on MAX_BURST consecutive edges.
- ready_in low stalls the burst. cnt holds, and the grant persists as long as the request stays high. There is no timeout.
- Request drops:
  - Granted request dropping while ready_in is high releases at that edge with no beat counted (valid_out = 0).
  - A request that drops before its first beat still updates ptr, so that source loses its turn.
- Non-granted requests are ignored until IDLE.
- If MAX_BURST = 1, every grant carries at most one beat.

## Test plan
- **Reset priority:** assert rst, release it, then raise req_in = 4'b1111 with ready_in = 1 and MAX_BURST = 4 -> grants in order 0,1,2,3,0. Each grant carries 4 beats. There is 1 idle cycle between grants. data_out equals a_in, b_in, c_in, d_in in turn.
- **Single requester:** req_in = 4'b0100 held, ready_in = 1 -> repeated grants to 2, 4 beats each, separated by one cycle with gnt_out = 0. sel_out stays 2'b10.
- **Backpressure:** grant to source 1, then hold ready_in = 0 for 5 cycles after beat 2 -> cnt stays 2 and valid_out stays 1. Release comes only after beats 3 and 4 once ready_in returns.
- **Early drop:** source 3 granted, drops req after 1 beat -> release at that edge, ptr = 3. The next grant goes to source 0 if it is requesting.
- **Async reset mid-burst:** assert rst between edges during beat 2 of a grant -> gnt_out = 0, valid_out = 0 immediately without a clock edge. After reset, arbitration restarts from source 0.
- **MAX_BURST = 1 build:** req_in = 4'b1010 -> grants alternate 1,3,1,3 with one beat each and a one-cycle bubble between grants.
